// File: rtl/pb_conditioner.sv
// Push-button front end: two-flop sync, tick-sampled debounce, edge pulses and
// lowest-key encoder with change strobe. Define PB_AUTOREPEAT_EN for key auto-repeat.
module pb_conditioner #(
    parameter int NUM_PB         = 21,
    parameter int SAMPLE_DIV     = 10000,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb,
    output logic [NUM_PB-1:0] pb_clean,
    output logic [NUM_PB-1:0] pb_rise,
    output logic [NUM_PB-1:0] pb_fall,
    output logic              key_valid,
    output logic [4:0]        key_idx,
    output logic              key_strobe,
    output logic              sample_tick
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    logic [NUM_PB-1:0]         sync1, sync2;
    logic [CW-1:0]             div_cnt, div_cnt_next;
    logic [STABLE_SAMPLES-1:0] sh      [NUM_PB];
    logic [STABLE_SAMPLES-1:0] sh_next [NUM_PB];
    logic [NUM_PB-1:0]         all_ones, all_zeros;
    logic                      enc_any, enc_change, rep_fire;
    logic [4:0]                enc_idx;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
        end
    end

    // sample_tick is registered so it is high exactly while div_cnt sits at its last value
    always_comb begin
        div_cnt_next = (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_next;
            sample_tick <= (div_cnt_next == CNT_LAST);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PB; i++) begin
            sh_next[i]   = {sh[i][STABLE_SAMPLES-2:0], sync2[i]};
            all_ones[i]  = &sh_next[i];
            all_zeros[i] = ~|sh_next[i];
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PB; i++) sh[i] <= '0;
            pb_clean <= '0;
            pb_rise  <= '0;
            pb_fall  <= '0;
        end else begin
            pb_rise <= '0;
            pb_fall <= '0;
            if (sample_tick) begin
                for (int i = 0; i < NUM_PB; i++) begin
                    sh[i] <= sh_next[i];
                    if (all_ones[i] && !pb_clean[i]) begin
                        pb_clean[i] <= 1'b1;
                        pb_rise[i]  <= 1'b1;
                    end else if (all_zeros[i] && pb_clean[i]) begin
                        pb_clean[i] <= 1'b0;
                        pb_fall[i]  <= 1'b0 | 1'b1;
                    end
                end
            end
        end
    end

    // With no key pressed the encoder keeps the previous index
    always_comb begin
        enc_any = |pb_clean;
        enc_idx = key_idx;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (pb_clean[i]) enc_idx = 5'(i);
        end
        enc_change = enc_any && (!key_valid || (enc_idx != key_idx));
    end

`ifdef PB_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt, rep_target;
    logic          rep_armed, tick_d;

    // Counting on the delayed tick keeps repeats on the same edges as encoder updates
    always_comb begin
        rep_target = rep_armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
        rep_fire   = enc_any && !enc_change && tick_d && ((rep_cnt + 1'b1) == rep_target);
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            tick_d    <= 1'b0;
        end else begin
            tick_d <= sample_tick;
            if (!enc_any || enc_change) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (tick_d) begin
                if (rep_fire) begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge hwclk) begin
        if (reset) begin
            key_valid  <= 1'b0;
            key_idx    <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_valid  <= enc_any;
            key_idx    <= enc_idx;
            key_strobe <= enc_change || rep_fire;
        end
    end

endmodule
